lynx_bank_mapper: RTL

Parametrised memory-map and loader-DMA block for the Lynx core family. It decodes CPU memory/IO strobes into RAM and video-plane write enables and a read-source select, generalising the fixed 48K/96K mapping to `VPLANES` planes and configurable ROM/RAM sizes. It adds a cycle-stealing loader port that writes downloaded tape/snapshot bytes into RAM and pulses an execution address on completion. The block sits between the CPU, the RAM/ROM/video-plane memories and the tape/ioctl loader in the machine top level.

---
 rtl/lynx_bank_mapper.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/lynx_bank_mapper.sv
`default_nettype none
// ============================================================================
// Module   : lynx_bank_mapper
// Purpose  : CPU memory/IO decode for RAM, ROM and video planes, plus a
//            cycle-stealing loader port that writes downloaded bytes to RAM.
// Revision : 1.0  initial release
// ============================================================================
module lynx_bank_mapper #(
   parameter int VPLANES = 3,
   parameter int RAM_AW  = 15,
   parameter int ROM_AW  = 14
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cep,
   input  logic [15:0]        a,
   input  logic               mreq,
   input  logic               iorq,
   input  logic               wr,
   input  logic [7:0]         cpu_do,
   output logic               ram_we,
   output logic [RAM_AW-1:0]  ram_addr,
   output logic [7:0]         ram_di,
   output logic [VPLANES-1:0] plane_we,
   output logic [1:0]         plane_rsel,
   output logic [1:0]         rd_src,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic [15:0]        ld_addr,
   input  logic [7:0]         ld_data,
   input  logic               ld_last,
   output logic               load_busy,
   output logic [15:0]        exec_addr,
   output logic               exec_set
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [16:0] c_rom_end = 17'(1) << ROM_AW;
   localparam logic [2:0]  c_vplanes = 3'(VPLANES);

   state_t            r_state;
   state_t            w_state_next;
   logic [7:0]        r_map;
   logic [1:0]        r_psel;
   logic [RAM_AW-1:0] r_ld_addr;
   logic [7:0]        r_ld_data;
   logic              r_ld_last;
   logic              r_first;
   logic              r_busy;
   logic [15:0]       r_exec_addr;

   logic w_io_wr;
   logic w_mem_wr;
   logic w_ld_accept;
   logic w_ld_write;
   logic w_in_rom;
   logic w_unused_map_bits;

   assign w_io_wr     = !iorq && !wr && cep;
   assign w_mem_wr    = !mreq && !wr && cep;
   assign w_ld_accept = ld_valid && (r_state == S_IDLE);
   // Loader only owns the RAM port on cep=0 cycles, when the CPU is never active.
   assign w_ld_write  = (r_state == S_WRITE) && !cep;
   assign w_in_rom    = ({1'b0, a} < c_rom_end);
   assign w_unused_map_bits = ^r_map;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_map  <= 8'h00;
         r_psel <= 2'd0;
      end else if (w_io_wr) begin
         if (a[6:0] == 7'h7F)
            r_map <= cpu_do;
         else if (a[6:0] == 7'h7E)
            r_psel <= cpu_do[1:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_ld_accept) w_state_next = S_WRITE;
         S_WRITE: if (!cep) w_state_next = r_ld_last ? S_DONE : S_IDLE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ld_addr   <= '0;
         r_ld_data   <= 8'h00;
         r_ld_last   <= 1'b0;
         r_first     <= 1'b1;
         r_busy      <= 1'b0;
         r_exec_addr <= 16'h0000;
      end else begin
         if (w_ld_accept) begin
            r_ld_addr <= ld_addr[RAM_AW-1:0];
            r_ld_data <= ld_data;
            r_ld_last <= ld_last;
            r_busy    <= 1'b1;
            if (r_first) begin
               r_exec_addr <= ld_addr;
               r_first     <= 1'b0;
            end
         end
         if (r_state == S_DONE) begin
            r_first <= 1'b1;
            r_busy  <= 1'b0;
         end
      end
   end

   assign ram_we     = w_ld_write || (w_mem_wr && !r_map[0]);
   assign ram_addr   = w_ld_write ? r_ld_addr : a[RAM_AW-1:0];
   assign ram_di     = w_ld_write ? r_ld_data : cpu_do;
   assign plane_we   = w_mem_wr ? r_map[4 +: VPLANES] : '0;
   assign plane_rsel = ({1'b0, r_psel} < c_vplanes) ? r_psel : 2'd0;

   always_comb begin
      rd_src = 2'd0;
      if (!mreq) begin
         if (!r_map[1] && w_in_rom)
            rd_src = 2'd1;
         else if (!r_map[2])
            rd_src = 2'd2;
         else if (r_map[3])
            rd_src = 2'd3;
      end
   end

   assign ld_ready  = (r_state == S_IDLE);
   assign load_busy = r_busy;
   assign exec_addr = r_exec_addr;
   assign exec_set  = (r_state == S_DONE);

endmodule
`default_nettype wire
